// File: rtl/dcache_refill_ctrl_pkg.sv
// Shared constants and FSM encoding for the data-cache refill controller.
package dcache_refill_ctrl_pkg;

  localparam int unsigned LINE_WORDS     = 16;
  localparam int unsigned DATA_BURST_NUM = LINE_WORDS - 1;
  localparam int unsigned LINE_OFF_W     = $clog2(LINE_WORDS * 4);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/dcache_refill_ctrl_line_buf.sv
// Line buffer: LINE_WORDS x 32 register file written one beat at a time.
module refill_line_buf #(
  parameter int unsigned LINE_WORDS = 16,
  localparam int unsigned IdxW = $clog2(LINE_WORDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [IdxW-1:0]          waddr,
  input  logic [31:0]              wdata,
  input  logic [IdxW-1:0]          rsel,
  output logic [LINE_WORDS*32-1:0] line,
  output logic [31:0]              word
);

  logic [LINE_WORDS-1:0][31:0] mem_q;

  // Beat write port; contents persist across bursts so short bursts leave stale words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign line = mem_q;
  assign word = mem_q[rsel];

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Read-miss refill engine: issues one AR (burst or single beat), gathers R beats
// into the line buffer and pulses resp_valid once the burst ends.
module dcache_refill_ctrl #(
  parameter int unsigned LINE_WORDS = dcache_refill_ctrl_pkg::LINE_WORDS,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic                     req_uncached,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic [LINE_WORDS*32-1:0] resp_line,
  output logic [31:0]              resp_word,
  output logic                     data_ren,
  output logic                     data_cache_ena,
  output logic [ADDR_W-1:0]        data_araddr,
  output logic                     data_arvalid,
  input  logic                     data_arready,
  input  logic [31:0]              data_rdata,
  input  logic                     data_rlast,
  input  logic                     data_rvalid,
  output logic                     data_rready
);
  import dcache_refill_ctrl_pkg::*;

  localparam int unsigned OffW = $clog2(LINE_WORDS * 4);
  localparam int unsigned IdxW = OffW - 2;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              uncached_q;
  logic [IdxW-1:0]   beat_cnt_q;
  logic [IdxW-1:0]   sel_q;
  logic              beat_we;
  logic [ADDR_W-1:0] ar_addr;

  // Cached refills fetch the whole aligned line; uncached reads go out as-is.
  assign ar_addr = uncached_q ? addr_q : {addr_q[ADDR_W-1:OffW], {OffW{1'b0}}};

  // State, request latch, beat counter and response word select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      uncached_q <= 1'b0;
      beat_cnt_q <= '0;
      sel_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_valid) begin
        addr_q     <= req_addr;
        uncached_q <= req_uncached;
      end
      if (beat_we) begin
        // Select moves only when new data lands, so resp_word holds until the next burst.
        sel_q <= uncached_q ? '0 : addr_q[OffW-1:2];
        if (data_rlast) begin
          beat_cnt_q <= '0;
        end else if (beat_cnt_q != LastIdx) begin
          beat_cnt_q <= beat_cnt_q + 1'b1;
        end
      end
    end
  end

  // Next-state and AXI-side outputs.
  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    data_ren       = 1'b0;
    data_cache_ena = 1'b0;
    data_arvalid   = 1'b0;
    data_araddr    = '0;
    data_rready    = 1'b0;
    beat_we        = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = StAddr;
      end
      StAddr: begin
        data_ren       = 1'b1;
        data_arvalid   = 1'b1;
        data_cache_ena = ~uncached_q;
        data_araddr    = ar_addr;
        if (data_arready) state_d = StData;
      end
      StData: begin
        data_ren       = 1'b1;
        data_rready    = 1'b1;
        data_cache_ena = ~uncached_q;
        if (data_rvalid) begin
          beat_we = 1'b1;
          if (data_rlast) state_d = StDone;
        end
      end
      StDone: begin
        resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  refill_line_buf #(
    .LINE_WORDS(LINE_WORDS)
  ) u_line_buf (
    .clk  (clk),
    .rst  (rst),
    .we   (beat_we),
    .waddr(beat_cnt_q),
    .wdata(data_rdata),
    .rsel (sel_q),
    .line (resp_line),
    .word (resp_word)
  );

endmodule
